// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU sharing front-end: opcodes, FSM states and
// the flag-class lookup that decides which architectural flags an op writes.
package alu_share_ctrl_pkg;

    localparam int W     = 16;
    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OPC_W-1:0] OP_XOR    = 4'b0010;
    localparam logic [OPC_W-1:0] OP_RED    = 4'b0011;
    localparam logic [OPC_W-1:0] OP_SLL    = 4'b0100;
    localparam logic [OPC_W-1:0] OP_SRA    = 4'b0101;
    localparam logic [OPC_W-1:0] OP_ROR    = 4'b0110;
    localparam logic [OPC_W-1:0] OP_PADDSB = 4'b0111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_Z    = 2'd1,
        FC_NZV  = 2'd2
    } flag_class_e;

    function automatic flag_class_e flag_class(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB:                 return FC_NZV;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: return FC_Z;
            default:                        return FC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// One requester channel: request valid/ready with ALU payload, and the
// registered response returned to that requester.
interface alu_share_ctrl_if;
    import alu_share_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [OPC_W-1:0] req_opcode;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic [3:0]       req_shamt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
            else                gnt_o = req_i;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[0])      last_d = 1'b0;
        else if (gnt_o[1]) last_d = 1'b1;
    end

    // Reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between the EX stage (port 0) and the helper
// path (port 1); registers the result and owns the Z/V/N flag register.
//   state   | meaning
//   IDLE    | no result held, either port may be granted
//   HOLD    | result held for owner_q until its rsp_ready
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  p0_if,
    alu_share_ctrl_if.slave  p1_if,
    output logic [W-1:0]     alu_in1_o,
    output logic [W-1:0]     alu_in2_o,
    output logic [OPC_W-1:0] alu_opcode_o,
    output logic [3:0]       alu_shamt_o,
    input  logic [W-1:0]     alu_out_i,
    input  logic             alu_z_i,
    input  logic             alu_n_i,
    input  logic             alu_v_i,
    output logic             flag_z_o,
    output logic             flag_v_o,
    output logic             flag_n_o
);

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [W-1:0]     result_q, result_d;
    logic             err_q, err_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_n_q, flag_n_d;
    logic [1:0]       gnt;
    logic             rsp_hs, arb_en, legal, sel_port;
    logic [OPC_W-1:0] sel_op;
    logic [3:0]       sel_shamt;
    logic [W-1:0]     sel_a, sel_b;

    assign rsp_hs = (state_q == ST_HOLD) && (owner_q ? p1_if.rsp_ready : p0_if.rsp_ready);
    // Readies are forced low while reset is asserted.
    assign arb_en = rst_n && ((state_q == ST_IDLE) || rsp_hs);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (arb_en),
        .req_i ({p1_if.req_valid, p0_if.req_valid}),
        .gnt_o (gnt)
    );

    assign p0_if.req_ready = gnt[0];
    assign p1_if.req_ready = gnt[1];

    assign sel_port  = gnt[1];
    assign sel_op    = sel_port ? p1_if.req_opcode : p0_if.req_opcode;
    assign sel_a     = sel_port ? p1_if.req_a      : p0_if.req_a;
    assign sel_b     = sel_port ? p1_if.req_b      : p0_if.req_b;
    assign sel_shamt = sel_port ? p1_if.req_shamt  : p0_if.req_shamt;
    assign legal     = ~sel_op[3];

    always_comb begin
        alu_opcode_o = OP_ADD;
        alu_in1_o    = '0;
        alu_in2_o    = '0;
        alu_shamt_o  = '0;
        if ((|gnt) && legal) begin
            alu_opcode_o = sel_op;
            alu_in1_o    = sel_a;
            alu_in2_o    = sel_b;
            alu_shamt_o  = sel_shamt;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        err_d    = err_q;
        flag_z_d = flag_z_q;
        flag_v_d = flag_v_q;
        flag_n_d = flag_n_q;
        if (|gnt) begin
            state_d  = ST_HOLD;
            owner_d  = sel_port;
            result_d = legal ? alu_out_i : '0;
            err_d    = ~legal;
            if (gnt[0] && legal) begin
                case (flag_class(sel_op))
                    FC_NZV: begin
                        flag_z_d = alu_z_i;
                        flag_v_d = alu_v_i;
                        flag_n_d = alu_n_i;
                    end
                    FC_Z:    flag_z_d = alu_z_i;
                    default: ;
                endcase
            end
        end else if (rsp_hs) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            err_q    <= err_d;
            flag_z_q <= flag_z_d;
            flag_v_q <= flag_v_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign p0_if.rsp_valid = (state_q == ST_HOLD) && !owner_q;
    assign p1_if.rsp_valid = (state_q == ST_HOLD) &&  owner_q;
    assign p0_if.rsp_data  = p0_if.rsp_valid ? result_q : '0;
    assign p1_if.rsp_data  = p1_if.rsp_valid ? result_q : '0;
    assign p0_if.rsp_err   = p0_if.rsp_valid && err_q;
    assign p1_if.rsp_err   = p1_if.rsp_valid && err_q;

    assign flag_z_o = flag_z_q;
    assign flag_v_o = flag_v_q;
    assign flag_n_o = flag_n_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl_if if0 ();
    alu_share_ctrl_if if1 ();

    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_opcode, alu_shamt;
    logic        alu_z, alu_n, alu_v;
    logic        flag_z, flag_v, flag_n;

    alu_share_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_if        (if0),
        .p1_if        (if1),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_opcode_o (alu_opcode),
        .alu_shamt_o  (alu_shamt),
        .alu_out_i    (alu_out),
        .alu_z_i      (alu_z),
        .alu_n_i      (alu_n),
        .alu_v_i      (alu_v),
        .flag_z_o     (flag_z),
        .flag_v_o     (flag_v),
        .flag_n_o     (flag_n)
    );

    // Reference ALU: returns {z, v, n, out}.
    function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] sh);
        logic [15:0] o;
        logic [31:0] t;
        logic        v;
        int          x, y;
        o = 16'h0;
        v = 1'b0;
        case (op)
            OP_ADD: begin o = a + b; v = (a[15] == b[15]) && (o[15] != a[15]); end
            OP_SUB: begin o = a - b; v = (a[15] != b[15]) && (o[15] != a[15]); end
            OP_XOR: o = a ^ b;
            OP_RED: o = {15'h0, ^a};
            OP_SLL: o = a << sh;
            OP_SRA: o = 16'($signed(a) >>> sh);
            OP_ROR: begin t = {a, a} >> sh; o = t[15:0]; end
            OP_PADDSB: begin
                x = int'($signed(a[15:8])) + int'($signed(b[15:8]));
                y = int'($signed(a[7:0]))  + int'($signed(b[7:0]));
                if (x > 127) x = 127;
                if (x < -128) x = -128;
                if (y > 127) y = 127;
                if (y < -128) y = -128;
                o = {x[7:0], y[7:0]};
            end
            default: o = 16'h0;
        endcase
        return {(o == 16'h0), v, o[15], o};
    endfunction

    always_comb {alu_z, alu_v, alu_n, alu_out} = alu_fn(alu_opcode, alu_in1, alu_in2, alu_shamt);

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit port, input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
        if (!port) begin
            if0.req_valid = v; if0.req_opcode = op; if0.req_a = a; if0.req_b = b; if0.req_shamt = sh;
        end else begin
            if1.req_valid = v; if1.req_opcode = op; if1.req_a = a; if1.req_b = b; if1.req_shamt = sh;
        end
    endtask

    // Model: at most one result outstanding; a new grant needs the slot free or
    // being freed this cycle; a tie goes to the preferred port, which then flips.
    bit          m_busy, m_owner, m_err, m_pref, m_z, m_v, m_n;
    logic [15:0] m_data;

    initial begin
        logic        rel, can, has_g, g, legal, own0, own1;
        logic [3:0]  op, sh;
        logic [15:0] a, b;
        logic [18:0] r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_err = 0; m_data = 16'h0; m_pref = 0;
                m_z = 0; m_v = 0; m_n = 0;
                check1("m_rst_req0_ready", if0.req_ready, 1'b0);
                check1("m_rst_req1_ready", if1.req_ready, 1'b0);
                check1("m_rst_rsp0_valid", if0.rsp_valid, 1'b0);
                check1("m_rst_rsp1_valid", if1.rsp_valid, 1'b0);
                check16("m_rst_flags", {13'h0, flag_z, flag_v, flag_n}, 16'h0);
            end else begin
                own0 = m_busy && !m_owner;
                own1 = m_busy && m_owner;
                check1("m_rsp0_valid", if0.rsp_valid, own0);
                check1("m_rsp1_valid", if1.rsp_valid, own1);
                check16("m_rsp0_data", if0.rsp_data, own0 ? m_data : 16'h0);
                check16("m_rsp1_data", if1.rsp_data, own1 ? m_data : 16'h0);
                check1("m_rsp0_err", if0.rsp_err, own0 && m_err);
                check1("m_rsp1_err", if1.rsp_err, own1 && m_err);
                check16("m_flags_zvn", {13'h0, flag_z, flag_v, flag_n}, {13'h0, m_z, m_v, m_n});

                rel   = m_busy && (m_owner ? if1.rsp_ready : if0.rsp_ready);
                can   = !m_busy || rel;
                has_g = can && (if0.req_valid || if1.req_valid);
                g     = (if0.req_valid && if1.req_valid) ? m_pref : if1.req_valid;
                check1("m_req0_ready", if0.req_ready, has_g && !g);
                check1("m_req1_ready", if1.req_ready, has_g && g);

                op = g ? if1.req_opcode : if0.req_opcode;
                a  = g ? if1.req_a      : if0.req_a;
                b  = g ? if1.req_b      : if0.req_b;
                sh = g ? if1.req_shamt  : if0.req_shamt;
                legal = !op[3];
                check16("m_alu_opcode", {12'h0, alu_opcode}, (has_g && legal) ? {12'h0, op} : 16'h0);
                check16("m_alu_in1", alu_in1, (has_g && legal) ? a : 16'h0);
                check16("m_alu_in2", alu_in2, (has_g && legal) ? b : 16'h0);
                check16("m_alu_shamt", {12'h0, alu_shamt}, (has_g && legal) ? {12'h0, sh} : 16'h0);

                if (has_g) begin
                    r = alu_fn(op, a, b, sh);
                    m_busy = 1; m_owner = g; m_err = !legal;
                    m_data = legal ? r[15:0] : 16'h0;
                    m_pref = !g;
                    if (!g && legal) begin
                        if (op == OP_ADD || op == OP_SUB) {m_z, m_v, m_n} = r[18:16];
                        else if (op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR) m_z = r[18];
                    end
                end else if (rel) begin
                    m_busy = 0;
                end
            end
        end
    end

    logic acc0, acc1;
    always @(posedge clk) begin
        acc0 <= if0.req_valid && if0.req_ready;
        acc1 <= if1.req_valid && if1.req_ready;
    end

    task automatic rnd_req(output logic v, output logic [3:0] op, output logic [15:0] a,
                           output logic [15:0] b, output logic [3:0] sh);
        logic [15:0] corners [4];
        corners = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        v  = ($urandom_range(0, 9) < 6);
        op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
        a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
        sh = 4'($urandom_range(0, 15));
    endtask

    initial begin
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        drv(1, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        if0.rsp_ready = 0;
        if1.rsp_ready = 0;

        #2;
        drv(0, 1, OP_ADD, 16'h1, 16'h1, 4'h0);
        drv(1, 1, OP_ADD, 16'h1, 16'h1, 4'h0);
        #1;
        check1("rst_req0_ready", if0.req_ready, 1'b0);
        check1("rst_req1_ready", if1.req_ready, 1'b0);
        check1("rst_rsp0_valid", if0.rsp_valid, 1'b0);
        check16("rst_flags", {13'h0, flag_z, flag_v, flag_n}, 16'h0);
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        drv(1, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        drv(1, 1, OP_SUB, 16'd5, 16'd5, 4'h0);
        if1.rsp_ready = 1;
        @(negedge clk) check1("sub_req1_ready", if1.req_ready, 1'b1);
        step();
        drv(1, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        check1("sub_rsp1_valid", if1.rsp_valid, 1'b1);
        check16("sub_rsp1_data", if1.rsp_data, 16'h0000);
        check1("sub_flag_z", flag_z, 1'b0);

        step();
        drv(0, 1, OP_ADD, 16'h7FFF, 16'h0001, 4'h0);
        if0.rsp_ready = 1;
        step();
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        check16("add_rsp0_data", if0.rsp_data, 16'h8000);
        check16("add_flags_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h0003);

        step();
        drv(0, 1, OP_XOR, 16'hAAAA, 16'hAAAA, 4'h0);
        step();
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        check16("xor_rsp0_data", if0.rsp_data, 16'h0000);
        check16("xor_flags_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h0007);

        step();
        drv(0, 1, 4'h9, 16'h1234, 16'h0001, 4'h3);
        @(negedge clk);
        check16("rsv_alu_opcode", {12'h0, alu_opcode}, 16'h0000);
        check16("rsv_alu_in1", alu_in1, 16'h0000);
        step();
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        check1("rsv_rsp0_err", if0.rsp_err, 1'b1);
        check16("rsv_rsp0_data", if0.rsp_data, 16'h0000);
        check16("rsv_flags_zvn", {13'h0, flag_z, flag_v, flag_n}, 16'h0007);

        step();
        if0.rsp_ready = 0;
        drv(0, 1, OP_ADD, 16'h0001, 16'h0001, 4'h0);
        step();
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        drv(1, 1, OP_XOR, 16'hF0F0, 16'h0F0F, 4'h0);
        if1.rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) check1("hold_req1_ready", if1.req_ready, 1'b0);
            step();
        end
        if0.rsp_ready = 1;
        @(negedge clk);
        check1("hold_req1_ready_rel", if1.req_ready, 1'b1);
        check16("hold_rsp0_data", if0.rsp_data, 16'h0002);
        step();
        drv(1, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        @(negedge clk);
        check1("hold_rsp1_valid", if1.rsp_valid, 1'b1);
        check16("hold_rsp1_data", if1.rsp_data, 16'hFFFF);
        check1("hold_rsp0_valid", if0.rsp_valid, 1'b0);

        step();
        drv(0, 1, OP_ADD, 16'h0001, 16'h0002, 4'h0);
        drv(1, 1, OP_ADD, 16'h0003, 16'h0004, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("alt_req0_ready", if0.req_ready, (i % 2) == 0);
            check1("alt_req1_ready", if1.req_ready, (i % 2) == 1);
            if (i % 2 == 1) begin
                check1("alt_rsp0_valid", if0.rsp_valid, 1'b1);
                check16("alt_rsp0_data", if0.rsp_data, 16'h0003);
            end else if (i > 0) begin
                check1("alt_rsp1_valid", if1.rsp_valid, 1'b1);
                check16("alt_rsp1_data", if1.rsp_data, 16'h0007);
            end
            step();
        end
        drv(1, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        if0.rsp_ready = 0;
        drv(0, 1, OP_ADD, 16'h7FFF, 16'h0001, 4'h0);
        step();
        drv(0, 0, 4'h0, 16'h0, 16'h0, 4'h0);
        drv(1, 1, OP_SUB, 16'h0009, 16'h0001, 4'h0);
        #3 rst_n = 0;
        #1;
        check1("midrst_rsp0_valid", if0.rsp_valid, 1'b0);
        check16("midrst_rsp0_data", if0.rsp_data, 16'h0000);
        check16("midrst_flags", {13'h0, flag_z, flag_v, flag_n}, 16'h0000);
        check1("midrst_req1_ready", if1.req_ready, 1'b0);
        @(negedge clk);
        step();
        rst_n = 1;
        drv(1, 0, 4'h0, 16'h0, 16'h0, 4'h0);

        for (int c = 0; c < 2000; c++) begin
            if (!if0.req_valid || acc0)
                rnd_req(if0.req_valid, if0.req_opcode, if0.req_a, if0.req_b, if0.req_shamt);
            if (!if1.req_valid || acc1)
                rnd_req(if1.req_valid, if1.req_opcode, if1.req_a, if1.req_b, if1.req_shamt);
            if0.rsp_ready = ($urandom_range(0, 3) != 0);
            if1.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbitration and sequencing front-end for the single 16-bit ALU. Two requesters share it through valid/ready channels: port 0 is the EX stage, port 1 is the multi-cycle helper path (address/debug). The block grants one operation at a time round-robin, drives the combinational ALU for one cycle, and registers the result. It also owns the architectural Z/V/N flag register, which only port 0 operations may update.

## Interface
- Parameters: none (width fixed at 16, opcode 4, shamt 4).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- reqN_opcode  in  4  ALU opcode (0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB)
- reqN_a, reqN_b  in  16  operands
- reqN_shamt  in  4  shift amount
- rspN_valid  out  1  result held for requester N
- rspN_ready  in  1  requester N consumes result
- rspN_data  out  16  registered ALU result
- rspN_err  out  1  reserved opcode (1xxx) rejected
- alu_in1, alu_in2  out  16  to ALU
- alu_opcode  out  4  to ALU
- alu_shamt  out  4  to ALU
- alu_out  in  16  from ALU (combinational)
- alu_z, alu_n, alu_v  in  1  ALU flags
- flag_z, flag_v, flag_n  out  1  architectural flag register

## Operation
- States: IDLE (no result held), HOLD (result held for owner, awaiting rspN_ready).
- Grant condition: state IDLE, or HOLD with the owner's rsp valid&ready this cycle (back-to-back allowed).
- Arbitration: only one valid -> grant it. Both valid -> grant the port not granted last; last_grant resets to 1, so port 0 wins the first tie.
- reqN_ready = grant to N (combinational from valids, state, and last_grant). At most one ready high per cycle.
- On grant: the granted port's opcode, operands and shamt are muxed onto the alu_* ports. alu_out and flags are captured at the clock edge into result_q and owner_q. State -> HOLD and rsp(owner)_valid=1 next cycle.
- With no grant, alu_* ports drive zero (opcode 0000).
- Reserved opcode (bit3=1): accepted normally, but the ALU is driven to zero, rsp_data=0x0000, rsp_err=1, and flags are unchanged.
- Flag update happens only on a port 0 grant with a legal opcode:
  - ADD/SUB update Z, V and N.
  - XOR/SLL/SRA/ROR update Z only.
  - RED/PADDSB leave all flags unchanged.
- Port 1 operations never touch the flags.
- rspN_data and rspN_err hold steady while rspN_valid is high. rsp of the non-owner is 0.

## Timing
- Latency: grant at cycle T -> rsp valid at T+1. Throughput is 1 op/cycle if the owner asserts rsp_ready every cycle.
- Flags become visible at T+1, together with rsp0_valid.
- Reset (async, any time, including mid-HOLD):
  - state IDLE, last_grant=1;
  - all rsp_valid/err=0, result_q=0;
  - flags Z=0, V=0, N=0;
  - all readies are combinationally 0 during reset.
- A request withdrawn before grant has no effect. Requests must hold their payload until ready (requester rule, not checked).
- Simultaneous owner response accept and a new grant to the other port: the response is released and the new result is loaded at the same edge.

## Structure
- Shared package holds the opcode constants (OP_ADD..OP_PADDSB), the flag-class function (NZV / Z-only / none) and the state enum.
- One natural sub-module, `rr_arb2`: a 2-way round-robin arbiter holding last_grant.
- The ALU itself stays instantiated at the level above; this block only drives its ports.

## Test plan
- Port 0 ADD 0x7FFF+0x0001 -> rsp0_data=0x8000 at T+1; flags Z=0, V=1, N=1.
- Both ports valid for 4 cycles with ready always high -> grants alternate 0,1,0,1; each rsp arrives at T+1.
- Port 1 SUB 5-5 -> rsp1_data=0x0000; flags unchanged from reset (Z=0).
- Port 0 XOR 0xAAAA^0xAAAA after an ADD that set V -> Z=1, V and N retained.
- Hold rsp0_ready=0 for 3 cycles with req1 valid -> req1_ready=0 throughout. On release, req1 is granted in the same cycle and rsp1 follows next cycle.
- Reserved opcode 0x9 on port 0 -> rsp0_err=1, data 0x0000, flags unchanged. Assert rst_n low mid-HOLD -> rsp and flags cleared immediately.
